// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch slice: FSM encoding,
// NOP word, PC step and J-type field widths.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam int          JIDX_W    = 26;
  localparam int          JREGION_W = 4;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection (branch > jump > sequential) and the
// out-of-range check for the current fetch address.
module mips_next_pc
  import mips_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic [31:0]          pc,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump,
  input  logic [JIDX_W-1:0]    jump_index,
  input  logic [JREGION_W-1:0] jump_region,
  output logic [31:0]          pc_plus4,
  output logic [31:0]          redirect_pc,
  output logic                 redirect,
  output logic                 out_of_range
);

  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

  logic [32:0] last_byte;

  assign pc_plus4 = pc + PC_INCR;
  assign redirect = branch_taken | jump;

  always_comb begin
    redirect_pc = pc_plus4;
    if (branch_taken) begin
      redirect_pc = branch_target & ~32'h0000_0003;
    end else if (jump) begin
      redirect_pc = {jump_region, jump_index, 2'b00};
    end
  end

  // 33-bit sum so a PC near the top of the address space cannot wrap back into range
  assign last_byte    = {1'b0, pc} + 33'd3;
  assign out_of_range = (last_byte >= IMEM_LIMIT);

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, IF/ID register and fetch FSM.
// Optional counters enabled with FETCH_PERF_CNT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | first cycle after reset, PC held, inputs ignored
// ST_RUN   | normal fetch: redirect / stall / capture by priority
// ST_FAULT | out-of-range fetch seen, everything frozen until reset
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_inst_o,
  output logic [31:0] ifid_pc4_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_o,
  output logic [15:0] perf_redirect_o,
`endif
  output logic        fetch_fault_o
);

  fetch_state_e state, state_nxt;

  logic [31:0] pc, pc_nxt;
  logic        ifid_valid, valid_nxt;
  logic [31:0] ifid_inst, inst_nxt;
  logic [31:0] ifid_pc4, pc4_nxt;
  logic        fetch_fault, fault_nxt;
  logic        capture, redirect_evt;

  logic [31:0] pc_plus4, redirect_pc;
  logic        redirect, out_of_range;

  mips_next_pc #(
    .IMEM_BYTES(IMEM_BYTES)
  ) u_next_pc (
    .pc            (pc),
    .branch_taken  (branch_taken_i),
    .branch_target (branch_target_i),
    .jump          (jump_i),
    .jump_index    (jump_index_i),
    .jump_region   (ifid_pc4[31:32-JREGION_W]),
    .pc_plus4      (pc_plus4),
    .redirect_pc   (redirect_pc),
    .redirect      (redirect),
    .out_of_range  (out_of_range)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= PC_RESET;
      ifid_valid  <= 1'b0;
      ifid_inst   <= NOP_WORD;
      ifid_pc4    <= 32'd0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ifid_valid  <= valid_nxt;
      ifid_inst   <= inst_nxt;
      ifid_pc4    <= pc4_nxt;
      fetch_fault <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    valid_nxt    = ifid_valid;
    inst_nxt     = ifid_inst;
    pc4_nxt      = ifid_pc4;
    fault_nxt    = fetch_fault;
    capture      = 1'b0;
    redirect_evt = 1'b0;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (redirect) begin
          pc_nxt       = redirect_pc;
          valid_nxt    = 1'b0;
          inst_nxt     = NOP_WORD;
          redirect_evt = 1'b1;
        end else if (out_of_range) begin
          fault_nxt = 1'b1;
          valid_nxt = 1'b0;
          inst_nxt  = NOP_WORD;
          state_nxt = ST_FAULT;
        end else if (!stall_i) begin
          inst_nxt  = imem_data_i;
          pc4_nxt   = pc_plus4;
          valid_nxt = 1'b1;
          pc_nxt    = pc_plus4;
          capture   = 1'b1;
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_BOOT;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [15:0] perf_redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch    <= 32'd0;
      perf_redirect <= 16'd0;
    end else begin
      if (capture) perf_fetch <= perf_fetch + 32'd1;
      if (redirect_evt && perf_redirect != 16'hFFFF) perf_redirect <= perf_redirect + 16'd1;
    end
  end

  assign perf_fetch_o    = perf_fetch;
  assign perf_redirect_o = perf_redirect;
`else
  logic unused_evt;
  assign unused_evt = capture ^ redirect_evt;
`endif

  assign imem_addr_o   = pc;
  assign pc_o          = pc;
  assign ifid_valid_o  = ifid_valid;
  assign ifid_inst_o   = ifid_inst;
  assign ifid_pc4_o    = ifid_pc4;
  assign fetch_fault_o = fetch_fault;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Table-driven bench for mips_fetch_unit with a queue scoreboard; perf
// counter checks are compiled only with FETCH_PERF_CNT_EN.
module tb_mips_fetch_unit;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] target;
    logic        jmp;
    logic [25:0] idx;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        e_fault;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, stall_i, branch_taken_i, jump_i;
  logic [31:0] branch_target_i;
  logic [25:0] jump_index_i;
  logic [31:0] imem_addr_o, imem_data_i, pc_o, ifid_inst_o, ifid_pc4_o;
  logic        ifid_valid_o, fetch_fault_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_o;
  logic [15:0] perf_redirect_o;
`endif

  logic [31:0] mem [256];
  vec_t        vecs[$];
  vec_t        sb[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    imem_data_i = 32'hDEAD_BEEF;
    if (imem_addr_o < 32'd1024) imem_data_i = mem[imem_addr_o[9:2]];
  end

  mips_fetch_unit #(
    .PC_RESET  (32'h0000_0000),
    .IMEM_BYTES(1024)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .jump_i         (jump_i),
    .jump_index_i   (jump_index_i),
    .imem_addr_o    (imem_addr_o),
    .imem_data_i    (imem_data_i),
    .pc_o           (pc_o),
    .ifid_valid_o   (ifid_valid_o),
    .ifid_inst_o    (ifid_inst_o),
    .ifid_pc4_o     (ifid_pc4_o),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_o   (perf_fetch_o),
    .perf_redirect_o(perf_redirect_o),
`endif
    .fetch_fault_o  (fetch_fault_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic st, input logic b, input logic [31:0] t,
                     input logic j, input logic [25:0] ix, input logic [31:0] pc,
                     input logic v, input logic [31:0] inst, input logic [31:0] pc4,
                     input logic f);
    vec_t x;
    x.rst_n = r; x.stall = st; x.br = b; x.target = t; x.jmp = j; x.idx = ix;
    x.e_pc = pc; x.e_valid = v; x.e_inst = inst; x.e_pc4 = pc4; x.e_fault = f;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, input logic st, input logic b, input logic [31:0] t,
                       input logic j, input logic [25:0] ix);
    rst_n = r; stall_i = st; branch_taken_i = b; branch_target_i = t;
    jump_i = j; jump_index_i = ix;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h0000_8020;
    mem[1] = 32'h2011_000A;
    mem[2] = 32'h2012_0014;
    mem[3] = 32'h0220_4020;
    mem[6] = 32'hAD09_0000;

    // reset, boot, then 10 sequential captures ending with ifid_pc4 = 0x28
    add(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    for (int k = 2; k <= 11; k++)
      add(1, 0, 0, 0, 0, 0, 32'(4 * (k - 1)), 1, mem[k - 2], 32'(4 * (k - 1)), 0);
    add(1, 0, 0, 0, 1, 26'd6, 32'h18, 0, 32'h0, 32'h28, 0);
    add(1, 0, 0, 0, 0, 0, 32'h1C, 1, 32'hAD09_0000, 32'h1C, 0);
    add(1, 1, 1, 32'h28, 1, 26'd3, 32'h28, 0, 32'h0, 32'h1C, 0);
    add(1, 0, 1, 32'h0E, 0, 0, 32'h0C, 0, 32'h0, 32'h1C, 0);
    for (int k = 0; k < 3; k++)
      add(1, 1, 0, 0, 0, 0, 32'h0C, 0, 32'h0, 32'h1C, 0);
    add(1, 0, 0, 0, 0, 0, 32'h10, 1, 32'h0220_4020, 32'h10, 0);
    add(1, 0, 1, 32'h400, 0, 0, 32'h400, 0, 32'h0, 32'h10, 0);
    add(1, 0, 0, 0, 0, 0, 32'h400, 0, 32'h0, 32'h10, 1);
    add(1, 0, 1, 32'h0, 1, 26'd1, 32'h400, 0, 32'h0, 32'h10, 1);
    add(1, 1, 0, 0, 0, 0, 32'h400, 0, 32'h0, 32'h10, 1);
    // reset wins over a simultaneous branch; boot cycle ignores redirects
    add(0, 0, 1, 32'h3FC, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 0, 1, 32'h3FC, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 0, 1, 32'h3FC, 0, 0, 32'h3FC, 0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h400, 1, mem[255], 32'h400, 0);
    add(1, 0, 0, 0, 0, 0, 32'h400, 0, 32'h0, 32'h400, 1);
    // top-of-address-space fetch must fault, not wrap into range
    add(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 1);

    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].target, vecs[i].jmp, vecs[i].idx);
      sb.push_back(vecs[i]);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: empty at vector %0d", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d pc", i), pc_o, e.e_pc);
        check($sformatf("v%0d addr", i), imem_addr_o, e.e_pc);
        check($sformatf("v%0d valid", i), 32'(ifid_valid_o), 32'(e.e_valid));
        check($sformatf("v%0d inst", i), ifid_inst_o, e.e_inst);
        check($sformatf("v%0d pc4", i), ifid_pc4_o, e.e_pc4);
        check($sformatf("v%0d fault", i), 32'(fetch_fault_o), 32'(e.e_fault));
      end
    end

`ifdef FETCH_PERF_CNT_EN
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("perf_fetch reset", perf_fetch_o, 32'd0);
    check("perf_redirect reset", 32'(perf_redirect_o), 32'd0);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    drive(1, 0, 1, 32'h0, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 1, 26'd2);
    @(posedge clk); #1;
    drive(1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("perf_fetch count", perf_fetch_o, 32'd10);
    check("perf_redirect count", 32'(perf_redirect_o), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the byte-addressed MIPS instruction memory. It owns the program counter, drives the memory address and captures the returned big-endian 32-bit word into the IF/ID pipeline register. Sequential PC+4 flow, jump redirect from ID, taken-branch redirect from EX, stall hold and flush are handled here. The instruction memory read is combinational in the same cycle.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset.
IMEM_BYTES, 1024, instruction memory size in bytes; fetches at or beyond it fault.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
stall_i  in  1  hold PC and IF/ID (hazard unit).
branch_taken_i  in  1  EX-stage taken branch; redirect and flush.
branch_target_i  in  32  byte address of the branch target.
jump_i  in  1  ID-stage J-type decoded; redirect and flush.
jump_index_i  in  26  instr[25:0] of the jump in ID.
imem_addr_o  out  32  byte address to instruction memory (= pc_o).
imem_data_i  in  32  instruction word from memory.
pc_o  out  32  current PC.
ifid_valid_o  out  1  IF/ID holds a live instruction.
ifid_inst_o  out  32  latched instruction (0x00000000 = NOP when invalid).
ifid_pc4_o  out  32  PC+4 of latched instruction.
fetch_fault_o  out  1  sticky out-of-range fetch flag.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at edge): pc=PC_RESET, ifid_valid=0, ifid_inst=0, ifid_pc4=0, fetch_fault=0, state=BOOT.
- FSM states: BOOT, RUN, FAULT.
  - BOOT: one cycle after reset; no capture; -> RUN. This cycle ignores stall_i, branch_taken_i and jump_i; pc holds.
  - RUN: each edge, actions are chosen by priority, highest first:
    1. branch_taken_i: pc<=branch_target_i with bits[1:0] forced 00; ifid_valid<=0; ifid_inst<=0.
    2. jump_i: pc<={ifid_pc4_o[31:28], jump_index_i, 2'b00}; flush IF/ID as in 1.
    3. stall_i: pc and IF/ID hold.
    4. Otherwise: ifid_inst<=imem_data_i; ifid_pc4<=pc+4; ifid_valid<=1; pc<=pc+4 (mod 2^32).
  - Redirect beats stall; branch beats jump (older instruction).
  - Range check: in RUN, if pc+3 >= IMEM_BYTES and no redirect is present, no capture occurs. Then fetch_fault<=1, ifid_valid<=0, ifid_inst<=0, state -> FAULT.
  - FAULT: pc and IF/ID frozen, fetch_fault=1. Only rst_n exits.
- Latency: the instruction at PC X appears on ifid_inst_o one edge after pc_o==X, if not stalled.
- Reset mid-operation overrides every input on the same edge.
- The range compare is done in 33 bits so that pc near 2^32 does not wrap into range.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_fetch_o[31:0] and perf_redirect_o[15:0].
  - perf_fetch_o increments on each RUN capture (priority 4).
  - perf_redirect_o increments on each branch or jump redirect and saturates at 16'hFFFF.
  - Both counters are cleared by reset.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - state encoding (BOOT/RUN/FAULT);
  - NOP word 32'h0000_0000;
  - PC increment constant 4;
  - J-type field widths (index 26 bits, region 4 bits).
- One natural sub-module, mips_next_pc: combinational next-PC select (branch/jump/seq) plus the range compare. The fetch unit keeps the registers and the FSM.

Test Plan:
- Reset then 4 free-running cycles, memory loaded with the 0x00008020, 0x2011000A, 0x20120014, 0x02204020 program -> cycle 2: ifid_inst=0x00008020, ifid_pc4=4. Cycle 5: ifid_inst=0x02204020, ifid_pc4=16, pc_o=16.
- Jump with ifid_pc4=0x28, jump_i=1, jump_index_i=6 -> next pc_o=0x18, ifid_valid=0. The next cycle captures the word at 0x18 (0xAD090000).
- branch_taken_i=1, target 0x28, asserted together with jump_i=1 and stall_i=1 -> pc_o=0x28, IF/ID flushed. The branch wins.
- stall_i held 3 cycles at pc=0x0C -> pc_o and ifid_inst frozen. Release -> capture 0x02204020.
- Branch to 0x400 with IMEM_BYTES=1024 -> next edge fetch_fault_o=1, ifid_valid=0. pc stays 0x400 despite stimulus until rst_n=0, which returns pc to 0 and clears the fault.
- With FETCH_PERF_CNT_EN: 10 sequential fetches plus 2 redirects -> perf_fetch_o=10, perf_redirect_o=2.
